regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the 2-way out-of-order core. It replaces the single-port 16x16 file. It provides NRD registered read ports and NWR write ports so that two instructions per cycle can read their operands and retire their results. It also keeps a per-register busy scoreboard, which the issue stage uses to tell whether an operand is available.

## Interface
Parameters:
- DATA_W, 16, register width in bits
- DEPTH, 16, number of registers
- ADDR_W, $clog2(DEPTH), register address width (derived)
- NRD, 4, number of read ports
- NWR, 2, number of write/alloc ports

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset
- rd_en  in  NRD  per-port read request
- rd_addr  in  NRD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  registered read data
- rd_valid  out  NRD  registered; high one cycle after the matching rd_en
- rd_busy  out  NRD  registered busy bit of the address that was read
- wr_en  in  NWR  per-port write (result writeback)
- wr_addr  in  NWR*ADDR_W  write addresses
- wr_data  in  NWR*DATA_W  write data
- alloc_en  in  NWR  mark the destination register busy (dispatch)
- alloc_addr  in  NWR*ADDR_W  registers to mark busy
- flush  in  1  clear all busy bits (mispredict recovery)

## Operation
- Reset is sampled at the posedge while rst==0. On reset: all DEPTH registers become 0, all busy bits become 0, and rd_data, rd_valid and rd_busy become 0. Any read that is in flight is dropped.
- Read, port i:
  - If rd_en[i] is high at an edge, rd_data[i] is loaded with the register value and rd_busy[i] with the busy bit, and rd_valid[i] goes high.
  - If rd_en[i] is low, rd_data[i] and rd_busy[i] hold their previous values and rd_valid[i] goes low.
- Write, port j: if wr_en[j] is high, register[wr_addr[j]] takes wr_data[j] at the edge and busy[wr_addr[j]] is cleared.
- Same address on several write ports in one cycle: the highest-indexed port wins for both data and the busy clear.
- Alloc, port j: if alloc_en[j] is high, busy[alloc_addr[j]] is set at the edge.
- Busy-bit priority, highest first:
  1. alloc: sets the bit even if a write or a flush targets the same register in that cycle.
  2. flush: clears all bits.
  3. write: clears the bit of its register.
- Reads on any number of ports may target the same address; there are no conflicts between read ports.
- All address inputs must be below DEPTH. Behaviour for out-of-range addresses is undefined; the bench must not drive them.

## Timing
- Read latency is 1 cycle: address at edge N, data valid after edge N.
- Write latency is 1 cycle: a read issued at edge N+1 or later sees the value written at edge N.
- A read and a write to the same address at the same edge: the result depends on the configuration macro below.
- Busy bits follow the same rule without a macro: rd_busy reflects the state before the edge.
- There is no backpressure; every port completes in one cycle.

## Configuration
- REGFILE_BYPASS_EN defined: same-edge write-to-read forwarding.
  - rd_data[i] returns the write data of the highest-indexed matching wr_en port.
  - rd_busy[i] returns the post-edge busy value, after applying the priority above.
- REGFILE_BYPASS_EN undefined: rd_data and rd_busy return the pre-edge array contents. This gives the smallest read mux.

## Structure
- Package regfile_pkg holds:
  - the default DATA_W, DEPTH and port counts;
  - a function giving the ADDR_W derivation;
  - the typedefs reg_addr_t and reg_data_t.
- Sub-module regfile_scoreboard holds the DEPTH busy bits and implements the alloc, flush and write-clear priority. It exports the current busy vector and the next-state busy vector; the next-state vector feeds the bypass read.
- The top level holds the storage array, write-port priority, read registers and optional bypass muxing.

## Test plan
- Reset with rst=0 for 2 cycles, then read addresses 0..15 on all 4 ports -> rd_data=0, rd_busy=0, and rd_valid high 1 cycle after each rd_en.
- Write 0x1234 to r3 on port 0 and 0xBEEF to r3 on port 1 in the same cycle; read r3 next cycle -> 0xBEEF.
- Write 0xA5A5 to r7 at edge N with rd_en for r7 at edge N (old value 0) -> rd_data 0xA5A5 with REGFILE_BYPASS_EN defined, 0x0000 without it; a read at N+1 gives 0xA5A5 in both builds.
- Scoreboard priority:
  - Alloc r5 in cycle 1; in cycle 2 write r5 while alloc r5 again -> busy[r5] stays 1.
  - Flush in cycle 3 with alloc r9 -> busy[r5]=0, busy[r9]=1.
- Reset mid-operation: assert rst in the same cycle as writes to r1/r2 and rd_en on all ports -> the writes are discarded, and the next-cycle rd_valid, rd_data and rd_busy are all 0.
- Four ports read r0, r0, r15, r15 in the same cycle after r15=0xFFFF -> rd_data = 0, 0, 0xFFFF, 0xFFFF.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and types for the multi-port register file.
//   DATA_W_DEF / DEPTH_DEF / NRD_DEF / NWR_DEF : default geometry
//   addr_w()      : register address width for a given depth
//   reg_addr_t    : register address at the default depth
//   reg_data_t    : register word at the default width
package regfile_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 16;
  localparam int NRD_DEF    = 4;
  localparam int NWR_DEF    = 2;

  // A single-entry file still needs a 1-bit address.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int ADDR_W_DEF = addr_w(DEPTH_DEF);

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write, alloc and flush bundle of the register file.
//   master : issue/retire side (drives requests, receives read results)
//   slave  : the register file itself
// Read port i uses rd_addr[i*ADDR_W +: ADDR_W] / rd_data[i*DATA_W +: DATA_W];
// write and alloc ports are packed the same way.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = addr_w(DEPTH),
  parameter int NRD    = NRD_DEF,
  parameter int NWR    = NWR_DEF
);

  logic [NRD-1:0]        rd_en;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_valid;
  logic [NRD-1:0]        rd_busy;
  logic [NWR-1:0]        wr_en;
  logic [NWR*ADDR_W-1:0] wr_addr;
  logic [NWR*DATA_W-1:0] wr_data;
  logic [NWR-1:0]        alloc_en;
  logic [NWR*ADDR_W-1:0] alloc_addr;
  logic                  flush;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
    input  rd_data, rd_valid, rd_busy
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
    output rd_data, rd_valid, rd_busy
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits.
//   clk, rst             : clock, synchronous active-low reset
//   alloc_en/alloc_addr  : set busy for dispatched destinations
//   flush                : clear every busy bit
//   wr_en/wr_addr        : clear busy for retired results
//   busy                 : current busy vector
//   busy_next            : busy vector after this edge (used for forwarding)
// Priority per register: alloc set > flush clear > write clear.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = addr_w(DEPTH),
  parameter int NWR    = NWR_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NWR-1:0]        alloc_en,
  input  logic [NWR*ADDR_W-1:0] alloc_addr,
  input  logic                  flush,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  output logic [DEPTH-1:0]      busy,
  output logic [DEPTH-1:0]      busy_next
);

  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next_c;

  // Apply lowest priority first so later steps override earlier ones.
  always_comb begin
    busy_next_c = busy_reg;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j]) busy_next_c[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (flush) busy_next_c = '0;
    for (int j = 0; j < NWR; j++) begin
      if (alloc_en[j]) busy_next_c[alloc_addr[j*ADDR_W +: ADDR_W]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) busy_reg <= '0;
    else      busy_reg <= busy_next_c;
  end

  assign busy      = busy_reg;
  assign busy_next = busy_next_c;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NRD-read / NWR-write register file with busy scoreboard.
//   clk  : clock, rising edge
//   rst  : synchronous active-low reset (clears registers, busy, read outputs)
//   bus  : regfile_mp_if.slave (read, write, alloc, flush)
// Reads are registered (1-cycle latency); rd_data/rd_busy hold when a port
// is idle. With REGFILE_BYPASS_EN defined a read at the same edge as a write
// to that register returns the new data and post-edge busy bit; otherwise
// reads see the pre-edge contents. Highest-indexed write port wins.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = addr_w(DEPTH),
  parameter int NRD    = NRD_DEF,
  parameter int NWR    = NWR_DEF
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

  logic [DATA_W-1:0]     mem_reg [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_next;
  logic [NRD*DATA_W-1:0] src_data;
  logic [NRD-1:0]        src_busy;
  logic [NRD*DATA_W-1:0] rd_data_reg;
  logic [NRD-1:0]        rd_valid_reg;
  logic [NRD-1:0]        rd_busy_reg;

  regfile_scoreboard #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .alloc_en  (bus.alloc_en),
    .alloc_addr(bus.alloc_addr),
    .flush     (bus.flush),
    .wr_en     (bus.wr_en),
    .wr_addr   (bus.wr_addr),
    .busy      (busy),
    .busy_next (busy_next)
  );

  // Ascending loop: the last non-blocking assignment (highest port) wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) mem_reg[k] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (bus.wr_en[j])
          mem_reg[bus.wr_addr[j*ADDR_W +: ADDR_W]] <= bus.wr_data[j*DATA_W +: DATA_W];
      end
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [ADDR_W-1:0] rd_a;
    assign rd_a = bus.rd_addr[gi*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    logic [DATA_W-1:0] fwd_data;
    always_comb begin
      fwd_data = mem_reg[rd_a];
      for (int j = 0; j < NWR; j++) begin
        if (bus.wr_en[j] && (bus.wr_addr[j*ADDR_W +: ADDR_W] == rd_a))
          fwd_data = bus.wr_data[j*DATA_W +: DATA_W];
      end
    end
    assign src_data[gi*DATA_W +: DATA_W] = fwd_data;
    assign src_busy[gi]                  = busy_next[rd_a];
`else
    assign src_data[gi*DATA_W +: DATA_W] = mem_reg[rd_a];
    assign src_busy[gi]                  = busy[rd_a];
`endif
  end

`ifndef REGFILE_BYPASS_EN
  // Next-state busy only matters for forwarding.
  logic unused_busy_next;
  assign unused_busy_next = ^busy_next;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= '0;
      rd_busy_reg  <= '0;
    end else begin
      rd_valid_reg <= bus.rd_en;
      for (int i = 0; i < NRD; i++) begin
        if (bus.rd_en[i]) begin
          rd_data_reg[i*DATA_W +: DATA_W] <= src_data[i*DATA_W +: DATA_W];
          rd_busy_reg[i]                  <= src_busy[i];
        end
      end
    end
  end

  assign bus.rd_data  = rd_data_reg;
  assign bus.rd_valid = rd_valid_reg;
  assign bus.rd_busy  = rd_busy_reg;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized + directed bench for regfile_mp.
// Driver applies inputs at the falling edge and pushes expected read
// results (from an array model of registers and busy bits) into per-port
// queues; a monitor samples #1 after each rising edge and compares.
// Honours REGFILE_BYPASS_EN the same way the design does.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int DW    = DATA_W_DEF;
  localparam int DEPTH = DEPTH_DEF;
  localparam int AW    = addr_w(DEPTH_DEF);
  localparam int NRD   = NRD_DEF;
  localparam int NWR   = NWR_DEF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .NRD(NRD), .NWR(NWR)) bus ();

  regfile_mp #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int unsigned stamp;
    reg_data_t   data;
    logic        busy;
  } exp_t;

  exp_t        exp_q [NRD][$];
  reg_data_t   m_mem [DEPTH];
  logic        m_busy[DEPTH];
  int          vectors     = 0;
  int          miscompares = 0;
  int unsigned cyc         = 0;

  task automatic check(input string name, input int p, input logic [31:0] act,
                       input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s port %0d cyc %0d: got %h expected %h", name, p, cyc, act, expv);
    end
  endtask

  task automatic clear_inputs();
    bus.rd_en      = '0;
    bus.rd_addr    = '0;
    bus.wr_en      = '0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.alloc_en   = '0;
    bus.alloc_addr = '0;
    bus.flush      = 1'b0;
  endtask

  task automatic set_rd(input int p, input int a);
    bus.rd_en[p]            = 1'b1;
    bus.rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int p, input int a, input int d);
    bus.wr_en[p]            = 1'b1;
    bus.wr_addr[p*AW +: AW] = AW'(a);
    bus.wr_data[p*DW +: DW] = DW'(d);
  endtask

  task automatic set_alloc(input int p, input int a);
    bus.alloc_en[p]            = 1'b1;
    bus.alloc_addr[p*AW +: AW] = AW'(a);
  endtask

  // Model one clock edge from the currently driven inputs, then advance.
  task automatic apply();
    reg_data_t new_mem [DEPTH];
    logic      new_busy[DEPTH];
    logic      wr_hit, al_hit;
    reg_addr_t a;
    exp_t      e;
    if (!rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        m_mem[r]  = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        wr_hit      = 1'b0;
        al_hit      = 1'b0;
        new_mem[r]  = m_mem[r];
        for (int j = 0; j < NWR; j++) begin
          if (bus.wr_en[j] && int'(bus.wr_addr[j*AW +: AW]) == r) begin
            new_mem[r] = bus.wr_data[j*DW +: DW];
            wr_hit     = 1'b1;
          end
          if (bus.alloc_en[j] && int'(bus.alloc_addr[j*AW +: AW]) == r) al_hit = 1'b1;
        end
        new_busy[r] = al_hit ? 1'b1 : bus.flush ? 1'b0 : wr_hit ? 1'b0 : m_busy[r];
      end
      for (int p = 0; p < NRD; p++) begin
        if (bus.rd_en[p]) begin
          a       = bus.rd_addr[p*AW +: AW];
          e.stamp = cyc + 1;
`ifdef REGFILE_BYPASS_EN
          e.data  = new_mem[a];
          e.busy  = new_busy[a];
`else
          e.data  = m_mem[a];
          e.busy  = m_busy[a];
`endif
          exp_q[p].push_back(e);
        end
      end
      m_mem  = new_mem;
      m_busy = new_busy;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor
  reg_data_t last_data[NRD];
  logic      last_busy[NRD];
  logic      rst_s;

  initial begin
    exp_t e;
    for (int p = 0; p < NRD; p++) begin
      last_data[p] = '0;
      last_busy[p] = 1'b0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      rst_s = rst;
      #1;
      for (int p = 0; p < NRD; p++) begin
        if (!rst_s) begin
          check("reset_out", p,
                {15'd0, bus.rd_valid[p], bus.rd_busy[p], bus.rd_data[p*DW +: DW]}, 32'd0);
          last_data[p] = '0;
          last_busy[p] = 1'b0;
        end else if (bus.rd_valid[p]) begin
          if (exp_q[p].size() == 0) begin
            check("unexpected_valid", p, 32'd1, 32'd0);
          end else begin
            e = exp_q[p].pop_front();
            check("rd_stamp", p, e.stamp, cyc);
            check("rd_data", p, 32'(bus.rd_data[p*DW +: DW]), 32'(e.data));
            check("rd_busy", p, 32'(bus.rd_busy[p]), 32'(e.busy));
            $display("read p%0d cyc %0d data %h busy %b", p, cyc,
                     bus.rd_data[p*DW +: DW], bus.rd_busy[p]);
            last_data[p] = e.data;
            last_busy[p] = e.busy;
          end
        end else begin
          if (exp_q[p].size() != 0 && exp_q[p][0].stamp <= cyc) begin
            e = exp_q[p].pop_front();
            check("missing_valid", p, 32'd0, 32'd1);
          end
          check("hold_data", p, 32'(bus.rd_data[p*DW +: DW]), 32'(last_data[p]));
          check("hold_busy", p, 32'(bus.rd_busy[p]), 32'(last_busy[p]));
        end
      end
    end
  end

  // Driver
  initial begin
    clear_inputs();
    // Reset with reads requested: they must be dropped.
    rst = 1'b0;
    for (int p = 0; p < NRD; p++) set_rd(p, p);
    apply();
    apply();
    rst = 1'b1;
    clear_inputs();

    // Every address on every port after reset.
    for (int a = 0; a < DEPTH; a++) begin
      clear_inputs();
      for (int p = 0; p < NRD; p++) set_rd(p, a);
      apply();
    end

    // Same-address double write: port 1 wins.
    clear_inputs(); set_wr(0, 3, 16'h1234); set_wr(1, 3, 16'hBEEF); apply();
    clear_inputs(); set_rd(0, 3); apply();

    // Read and write of r7 at the same edge, then a plain read.
    clear_inputs(); set_wr(0, 7, 16'hA5A5); set_rd(1, 7); apply();
    clear_inputs(); set_rd(2, 7); apply();

    // Scoreboard priority.
    clear_inputs(); set_alloc(0, 5); apply();
    clear_inputs(); set_wr(0, 5, 16'h0055); set_alloc(1, 5); set_rd(0, 5); apply();
    clear_inputs(); bus.flush = 1'b1; set_alloc(0, 9); set_rd(0, 5); set_rd(1, 9); apply();
    clear_inputs(); set_rd(0, 5); set_rd(1, 9); apply();

    // Reset mid-operation.
    clear_inputs(); set_wr(0, 1, 16'h1111); set_wr(1, 2, 16'h2222); apply();
    clear_inputs(); set_wr(0, 1, 16'h3333); set_wr(1, 2, 16'h4444);
    for (int p = 0; p < NRD; p++) set_rd(p, 1 + (p % 2));
    rst = 1'b0; apply(); rst = 1'b1;
    clear_inputs(); set_rd(0, 1); set_rd(1, 2); set_rd(2, 9); apply();

    // Duplicate reads of r0 and r15.
    clear_inputs(); set_wr(1, 15, 16'hFFFF); apply();
    clear_inputs(); set_rd(0, 0); set_rd(1, 0); set_rd(2, 15); set_rd(3, 15); apply();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      clear_inputs();
      rst = ($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1;
      for (int p = 0; p < NRD; p++)
        if ($urandom_range(0, 3) != 0) set_rd(p, $urandom_range(0, DEPTH - 1));
      for (int j = 0; j < NWR; j++) begin
        if ($urandom_range(0, 1) == 1)
          set_wr(j, $urandom_range(0, DEPTH - 1), $urandom_range(0, 16'hFFFF));
        if ($urandom_range(0, 2) == 0) set_alloc(j, $urandom_range(0, DEPTH - 1));
      end
      // Bias toward collisions between read, write and alloc addresses.
      if ($urandom_range(0, 3) == 0 && bus.wr_en[0]) begin
        bus.rd_addr[0 +: AW]   = bus.wr_addr[0 +: AW];
        bus.alloc_addr[0 +: AW] = bus.wr_addr[0 +: AW];
      end
      bus.flush = ($urandom_range(0, 9) == 0);
      apply();
    end

    rst = 1'b1;
    clear_inputs();
    apply();
    apply();
    for (int p = 0; p < NRD; p++)
      check("queue_drained", p, exp_q[p].size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
